// File: rtl/color_step_ctrl.sv
// Palette stepper: forward/backward keys walk an index through a color ROM with
// hold-then-repeat auto-stepping, and a two-stage fetch pipeline registers the color.
module color_step_ctrl #(
  parameter int NUM_COLORS    = 16,
  parameter int ADDR_W        = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              forward,
  input  logic              backward,
  input  logic              lock,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [23:0]       colorHex,
  output logic              color_valid,
  output logic              color_changed
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(NUM_COLORS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              dir;
  logic              fwd_k, bwd_k, key, same_key;
  logic              step, step_dir, cnt_inc;
  logic              init_done, vld_p0, vld_p1;

  function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] cur,
                                                   input logic fwd);
    if (fwd) return (cur == IDX_LAST) ? '0 : cur + 1'b1;
    else     return (cur == '0) ? IDX_LAST : cur - 1'b1;
  endfunction

  assign fwd_k    = forward & ~backward & ~lock;
  assign bwd_k    = backward & ~forward & ~lock;
  assign key      = fwd_k | bwd_k;
  // A held key only counts if it is the one that started the press.
  assign same_key = dir ? fwd_k : bwd_k;
  assign rom_addr = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key) state_nxt = HOLD;
      HOLD:    if (!same_key) state_nxt = IDLE;
               else if (cnt == HOLD_LAST) state_nxt = REPEAT;
      REPEAT:  if (!same_key) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (lock) state_nxt = IDLE;
  end

  always_comb begin
    step     = 1'b0;
    step_dir = dir;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: if (key) begin
        step     = 1'b1;
        step_dir = fwd_k;
      end
      HOLD: if (same_key) begin
        if (cnt == HOLD_LAST) step = 1'b1;
        else                  cnt_inc = 1'b1;
      end
      REPEAT: if (same_key) begin
        if (cnt == REPEAT_LAST) step = 1'b1;
        else                    cnt_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      cnt <= '0;
      dir <= 1'b1;
    end else begin
      cnt <= cnt_inc ? cnt + 1'b1 : '0;
      if (step) begin
        idx <= next_index(idx, step_dir);
        dir <= step_dir;
      end
    end
  end

  // p0: address presented to ROM; p1: ROM data on the bus; load colorHex after p1.
  // Fetches stay in order, so an older one can never land after a newer one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_done     <= 1'b0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      colorHex      <= '0;
      color_valid   <= 1'b0;
      color_changed <= 1'b0;
    end else begin
      init_done     <= 1'b1;
      vld_p0        <= step | ~init_done;
      vld_p1        <= vld_p0;
      color_changed <= vld_p1;
      if (vld_p1) colorHex <= rom_data;
      if (step)                   color_valid <= 1'b0;
      else if (vld_p1 && !vld_p0) color_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_color_step_ctrl.sv
// Directed bench for color_step_ctrl: expected colors are queued by the stimulus
// and checked by a monitor on every color_changed pulse.
module tb_color_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        forward = 1'b0, backward = 1'b0, lock = 1'b0;
  logic [3:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] colorHex;
  logic        color_valid, color_changed;

  int          n_vec = 0, n_err = 0, n_push = 0, n_pulse = 0;
  logic [23:0] exp_q[$];

  color_step_ctrl #(
    .NUM_COLORS(16), .ADDR_W(4), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .forward(forward), .backward(backward), .lock(lock),
    .rom_addr(rom_addr), .rom_data(rom_data), .colorHex(colorHex),
    .color_valid(color_valid), .color_changed(color_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 24'h000100 * rom_addr + 24'h11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_color(input logic [23:0] c);
    exp_q.push_back(c);
    n_push++;
  endtask

  // Monitor: every colorHex update must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (color_changed) begin
        n_pulse++;
        if (exp_q.size() == 0) chk("unexpected_color_changed", {8'h0, colorHex}, 32'hFFFFFFFF);
        else                   chk("colorHex_on_pulse", {8'h0, colorHex}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_idx[10] = '{2, 2, 2, 2, 3, 3, 4, 4, 5, 5};

    // Reset state
    tick(2);
    chk("rst_colorHex", colorHex, 0);
    chk("rst_valid", color_valid, 0);
    chk("rst_changed", color_changed, 0);
    chk("rst_addr", rom_addr, 0);

    // Reset release: initial fetch of ROM[0]
    reset = 1'b1;
    expect_color(24'h000011);
    tick(3);
    chk("init_colorHex", colorHex, 24'h000011);
    chk("init_valid", color_valid, 1);
    chk("init_addr", rom_addr, 0);
    tick(2);

    // Single forward press
    forward = 1'b1;
    expect_color(24'h000111);
    tick(1);
    forward = 1'b0;
    chk("press_addr", rom_addr, 1);
    chk("press_valid_low", color_valid, 0);
    tick(2);
    chk("press_colorHex", colorHex, 24'h000111);
    chk("press_valid_high", color_valid, 1);
    tick(10);
    chk("press_no_repeat", rom_addr, 1);

    // Held forward: steps at cycles 0, 4, 6, 8
    forward = 1'b1;
    expect_color(24'h000211);
    expect_color(24'h000311);
    expect_color(24'h000411);
    expect_color(24'h000511);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("hold_addr_c%0d", i), rom_addr, exp_idx[i]);
    end
    forward = 1'b0;
    tick(3);
    chk("hold_colorHex", colorHex, 24'h000511);
    chk("hold_valid", color_valid, 1);
    chk("hold_queue_drained", exp_q.size(), 0);

    // Reset mid-fetch: the pending ROM[6] load must be discarded
    forward = 1'b1;
    tick(1);
    forward = 1'b0;
    chk("midfetch_addr", rom_addr, 6);
    tick(1);
    reset = 1'b0;
    #1;
    chk("midfetch_rst_colorHex", colorHex, 0);
    chk("midfetch_rst_valid", color_valid, 0);
    chk("midfetch_rst_addr", rom_addr, 0);
    tick(3);
    chk("midfetch_held_colorHex", colorHex, 0);
    reset = 1'b1;
    expect_color(24'h000011);
    tick(3);
    chk("rerelease_colorHex", colorHex, 24'h000011);
    chk("rerelease_valid", color_valid, 1);

    // Wrap backward 0 -> 15 and forward 15 -> 0
    backward = 1'b1;
    expect_color(24'h000F11);
    tick(1);
    backward = 1'b0;
    tick(3);
    chk("wrapb_addr", rom_addr, 15);
    chk("wrapb_colorHex", colorHex, 24'h000F11);
    forward = 1'b1;
    expect_color(24'h000011);
    tick(1);
    forward = 1'b0;
    tick(3);
    chk("wrapf_addr", rom_addr, 0);
    chk("wrapf_colorHex", colorHex, 24'h000011);

    // Both keys high: never step
    forward = 1'b1;
    backward = 1'b1;
    tick(8);
    chk("both_addr", rom_addr, 0);
    forward = 1'b0;
    backward = 1'b0;
    tick(1);

    // Lock freezes selection; releasing it with forward held steps once
    lock = 1'b1;
    forward = 1'b1;
    tick(8);
    chk("lock_addr", rom_addr, 0);
    chk("lock_colorHex", colorHex, 24'h000011);
    lock = 1'b0;
    expect_color(24'h000111);
    tick(1);
    chk("unlock_addr", rom_addr, 1);
    forward = 1'b0;
    tick(3);
    chk("unlock_colorHex", colorHex, 24'h000111);
    chk("unlock_valid", color_valid, 1);

    tick(3);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("pulse_count", n_pulse, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/color_step_ctrl.md
COLOR_STEP_CTRL -- requirements
Module: color_step_ctrl

Interface
REQ-001 Parameter NUM_COLORS, default 16: number of palette entries in the color ROM.
REQ-002 Parameter ADDR_W, default 4: ROM address width; NUM_COLORS SHALL be at most 2**ADDR_W.
REQ-003 Parameter HOLD_CYCLES, default 25_000_000: cycles a key is held before auto-repeat starts.
REQ-004 Parameter REPEAT_CYCLES, default 5_000_000: cycles between auto-repeat steps.
REQ-005 clk  input  1: single system clock; all state changes on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 forward  input  1: level, synchronous to clk; step to the next color.
REQ-008 backward  input  1: level, synchronous to clk; step to the previous color.
REQ-009 lock  input  1: level; freezes color selection while high (painting in progress).
REQ-010 rom_addr  output  ADDR_W: address to the external synchronous color ROM; equals the index register.
REQ-011 rom_data  input  24: ROM read data, valid one cycle after rom_addr changes.
REQ-012 colorHex  output  24: registered current color, RGB 8:8:8.
REQ-013 color_valid  output  1: high when colorHex matches the current index.
REQ-014 color_changed  output  1: one-cycle pulse on each colorHex update.

Function
REQ-015 FSM states: IDLE, HOLD, REPEAT; index register 0..NUM_COLORS-1; cycle counter sized for max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-016 Effective key: fwd_k = forward & ~backward & ~lock; bwd_k = backward & ~forward & ~lock; key = fwd_k | bwd_k.
REQ-017 IDLE, key high: step index once in the key direction, clear counter, go HOLD.
REQ-018 HOLD: counter increments each cycle while the same key stays high; when counter reaches HOLD_CYCLES-1, step once, clear counter, go REPEAT.
REQ-019 REPEAT: counter increments; when it reaches REPEAT_CYCLES-1, step once and clear counter; stay in REPEAT.
REQ-020 HOLD or REPEAT, key low, direction change, or both keys high: no step, clear counter, go IDLE; a new press is taken only from IDLE, so a new step comes at the earliest one cycle after return to IDLE.
REQ-021 Wrap: forward from NUM_COLORS-1 goes to 0; backward from 0 goes to NUM_COLORS-1; no other wrap.
REQ-022 lock high: index frozen, FSM forced to IDLE, counter cleared; colorHex keeps its value.
REQ-023 Fetch pipeline: index changes at edge T; rom_data valid during T+1; colorHex loads rom_data at edge T+2; color_changed high for the cycle after T+2.
REQ-024 color_valid goes low at edge T and returns high at edge T+2; a further step inside that window restarts the window from the new T.
REQ-025 Every index change, including one forced by reset exit, issues exactly one colorHex load; a stale fetch SHALL NOT overwrite a newer fetch.
REQ-026 At most one step per cycle; simultaneous forward and backward never step.

Reset
REQ-027 reset low, asynchronously: state IDLE, index 0, counter 0, colorHex 0, color_valid 0, color_changed 0.
REQ-028 First rising clk edge after reset release, called R: initial fetch of index 0 starts; colorHex loads ROM[0] at edge R+2 with color_valid 1 and one color_changed pulse.
REQ-029 reset asserted mid-hold or mid-fetch: all state returns to reset values immediately; the pending fetch is discarded.

Verification (bench sets HOLD_CYCLES=4, REPEAT_CYCLES=2, NUM_COLORS=16; ROM model returns 24'h000100*addr + 24'h11)
REQ-030 Release reset, wait 3 cycles -> rom_addr 0, colorHex 24'h000011, color_valid 1, exactly one color_changed pulse.
REQ-031 forward high 1 cycle then low -> index 1, colorHex 24'h000111 two cycles later, no further steps over 10 idle cycles.
REQ-032 forward held 10 cycles from index 1 -> steps at cycles 0, 4, 6, 8, giving index 5; colorHex tracks each step with 2-cycle latency.
REQ-033 From index 0, backward 1-cycle press -> index 15, colorHex 24'h000F11; from index 15, forward press -> index 0.
REQ-034 forward and backward both high 8 cycles -> no index change; lock high with forward held 8 cycles -> no change; lock low with forward still held -> one immediate step.
REQ-035 Assert reset 1 cycle after a step, mid-fetch -> colorHex 0, color_valid 0 at once; after release, colorHex ROM[0] appears and the discarded fetch value never appears.
